sar_readout_serializer: RTL and testbench
=========================================

# sar_readout_serializer

Readout end of the two-step (coarse/fine) 10-bit SAR ADC. Issues `cnvst` to the SAR logic, waits for the `eoc` rising edge and captures `sar[9:0]`. It then shifts the code out MSB-first on a 3-wire serial link (`ser_clk`, `sdo`, `frame`) and paces conversions at a fixed period. It sits between the SAR logic block and the off-chip or test-chip readout pins.

## Interface
- `WIDTH`, 10: SAR code width.
- `CONV_PERIOD`, 64: clk cycles from one `cnvst` assertion to the next; must be ≥ 2*WIDTH+4.
- `TIMEOUT`, 40: max clk cycles in CONV waiting for `eoc` (used only with the timeout feature).
- `clk` input 1: system clock, single clock domain; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: run enable; sampled in IDLE only.
- `eoc` input 1: end of conversion from SAR logic, synchronous to `clk`.
- `sar` input WIDTH: conversion result; valid when `eoc` is high.
- `cnvst` output 1: conversion start to SAR logic.
- `ser_clk` output 1: serial clock; receiver samples `sdo` on its rising edge.
- `sdo` output 1: serial data, MSB first.
- `frame` output 1: high for the entire serial word.
- `conv_count` output 16: completed (serialized) conversions; wraps 0xFFFF→0.
- `overrun` output 1: sticky; period expired before serialization finished.
- `timeout_flag` output 1: sticky; `eoc` never arrived (tied 0 without the macro).

## Operation
- States: IDLE, CONV, SHIFT, GAP.
- **IDLE**
  - `cnvst`=0.
  - If `en`=1: next state CONV; period counter cleared to 0.
- **CONV**
  - `cnvst`=1.
  - `eoc_q` is `eoc` registered. A rising edge is `eoc`=1 and `eoc_q`=0.
  - On a rising edge: load `sar` into the shift register, then go to SHIFT.
  - An `eoc` already high on entry is ignored until it falls and rises again.
- **SHIFT**
  - `cnvst`=0, `frame`=1.
  - Each bit occupies 2 clk cycles: `ser_clk`=0 in the first, 1 in the second.
  - `sdo` changes only when `ser_clk` goes 0.
  - After WIDTH bits: `conv_count` increments and the next state is GAP.
- **GAP**
  - `frame`=0, `ser_clk`=0, `sdo`=0.
  - When the period counter reaches CONV_PERIOD-1: go to CONV if `en`=1, else IDLE. The period counter clears in both cases.
- **Period counter**
  - Increments every cycle outside IDLE and saturates at CONV_PERIOD-1.
  - If it saturates while in CONV or SHIFT: set `overrun`. The current word still completes, and GAP exits on its first cycle.
- **`en` deassertion** outside IDLE finishes the current conversion and word, then parks in IDLE. No truncated frames.
- **Sticky flags** clear only on `rst`.

## Timing
- Reset (async) values:
  - State IDLE.
  - `cnvst`, `ser_clk`, `sdo`, `frame` = 0.
  - `conv_count` = 0.
  - `overrun`, `timeout_flag` = 0.
  - Shift register = 0.
  - Period counter = 0.
- `rst` mid-conversion or mid-frame forces all outputs to reset values immediately, with no completion.
- `en`=1 at edge N in IDLE → `cnvst`=1 after edge N.
- `eoc` rising sampled at edge M → at edge M:
  - `cnvst`=0, `frame`=1, `ser_clk`=0, `sdo`=`sar[WIDTH-1]`.
  - At edge M+1: `ser_clk`=1.
  - Bit k (MSB = k 0) is driven from edge M+2k.
- `frame` falls at edge M+2*WIDTH, together with the `conv_count` increment.
- Capture latency from `eoc` edge to first `sdo` bit: 0 cycles after the capturing edge.

## Configuration
- `SAR_READOUT_TIMEOUT_EN`
  - **Defined:** a CONV dwell counter counts cycles in CONV. When it reaches TIMEOUT without an `eoc` rising edge:
    - `timeout_flag` sets, `cnvst` drops, and no frame is sent.
    - `conv_count` is unchanged and the next state is GAP.
    - The period counter keeps running, so the next attempt starts on schedule.
  - **Undefined:** CONV waits indefinitely, and `timeout_flag` is a constant 0.

## Test plan
- **Reset:** `rst`=1 at t=0 and released at 30 ns, `en`=0 → outputs stay at reset values and `cnvst`=0 indefinitely.
- **Basic frame:** `en`=1, `eoc` pulses high 12 cycles after `cnvst` rises with `sar`=10'h2A5 →
  - `frame` high for exactly 20 cycles.
  - Bits sampled on `ser_clk` rising = 1010100101.
  - `conv_count`=1.
  - Next `cnvst` rises 64 cycles after the first.
- **Stuck-high `eoc`:** `eoc` already high when CONV is entered, falls after 3 cycles, rises after 8 → capture occurs only at the second rising edge.
- **Overrun:** CONV_PERIOD=24, `eoc` arrives 10 cycles after `cnvst` → `overrun`=1, the full 20-cycle frame is still sent, and the next `cnvst` follows GAP after 1 cycle.
- **`en` drop:** `en`=0 mid-SHIFT → the frame completes, the block returns to IDLE, and no further `cnvst` is issued. Reasserting `en` restarts within 1 cycle.
- **Timeout (macro defined):** `eoc` held 0 → `cnvst` drops after 40 cycles, `timeout_flag`=1, `frame` never rises, `conv_count` stays 0. With the macro undefined, `cnvst` stays high.

Source files
------------

// File: rtl/sar_readout_serializer_if.sv
// rtl/sar_readout_serializer_if.sv - SAR handshake and 3-wire serial link bundle
interface sar_readout_serializer_if #(
    parameter int WIDTH = 10
);
    logic             cnvst;
    logic             eoc;
    logic [WIDTH-1:0] sar;
    logic             ser_clk;
    logic             sdo;
    logic             frame;

    // Readout block side: drives conversion start and the serial pins
    modport master (
        output cnvst, ser_clk, sdo, frame,
        input  eoc, sar
    );

    // SAR logic / pin receiver side
    modport slave (
        input  cnvst, ser_clk, sdo, frame,
        output eoc, sar
    );
endinterface

// File: rtl/sar_readout_serializer.sv
// rtl/sar_readout_serializer.sv - SAR capture and MSB-first serializer; optional macro SAR_READOUT_TIMEOUT_EN
module sar_readout_serializer #(
    parameter int WIDTH       = 10,
    parameter int CONV_PERIOD = 64,
    parameter int TIMEOUT     = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    sar_readout_serializer_if.master    bus,
    output logic [15:0]                 conv_count,
    output logic                        overrun,
    output logic                        timeout_flag
);

    localparam int PW = $clog2(CONV_PERIOD);
    localparam int HW = $clog2(2 * WIDTH);
    localparam logic [PW-1:0] PER_MAX  = PW'(CONV_PERIOD - 1);
    localparam logic [HW-1:0] HALF_MAX = HW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      per_q, per_d;
    logic [HW-1:0]      half_q, half_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               eoc_q, eoc_d;
    logic               cnvst_q, cnvst_d;
    logic               ser_clk_q, ser_clk_d;
    logic               sdo_q, sdo_d;
    logic               frame_q, frame_d;
    logic [15:0]        count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               eoc_rise;
    logic               per_max;

`ifdef SAR_READOUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] DWELL_MAX = TW'(TIMEOUT - 1);
    logic [TW-1:0]      dwell_q, dwell_d;
    logic               tmo_q, tmo_d;
`endif

    // State register and all registered outputs; async reset parks everything idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            per_q     <= '0;
            half_q    <= '0;
            shreg_q   <= '0;
            eoc_q     <= 1'b0;
            cnvst_q   <= 1'b0;
            ser_clk_q <= 1'b0;
            sdo_q     <= 1'b0;
            frame_q   <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
`ifdef SAR_READOUT_TIMEOUT_EN
            dwell_q   <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            eoc_q     <= eoc_d;
            cnvst_q   <= cnvst_d;
            ser_clk_q <= ser_clk_d;
            sdo_q     <= sdo_d;
            frame_q   <= frame_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
`ifdef SAR_READOUT_TIMEOUT_EN
            dwell_q   <= dwell_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Next-state logic: pacing, eoc edge capture, bit shifting and sticky flags
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        half_d    = half_q;
        shreg_d   = shreg_q;
        eoc_d     = bus.eoc;
        cnvst_d   = cnvst_q;
        ser_clk_d = ser_clk_q;
        sdo_d     = sdo_q;
        frame_d   = frame_q;
        count_d   = count_q;
        overrun_d = overrun_q;
`ifdef SAR_READOUT_TIMEOUT_EN
        dwell_d   = dwell_q;
        tmo_d     = tmo_q;
`endif
        // eoc_q tracks eoc in every state, so a level already high on CONV entry is not an edge
        eoc_rise  = bus.eoc & ~eoc_q;
        per_max   = (per_q == PER_MAX);

        // Period counter runs outside IDLE and holds once the period has expired
        if (state_q != IDLE && !per_max) begin
            per_d = per_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = CONV;
                    per_d   = '0;
                    cnvst_d = 1'b1;
`ifdef SAR_READOUT_TIMEOUT_EN
                    dwell_d = '0;
`endif
                end
            end

            CONV: begin
                if (per_max) begin
                    overrun_d = 1'b1;
                end
`ifdef SAR_READOUT_TIMEOUT_EN
                dwell_d = dwell_q + 1'b1;
`endif
                if (eoc_rise) begin
                    state_d   = SHIFT;
                    shreg_d   = bus.sar;
                    half_d    = '0;
                    cnvst_d   = 1'b0;
                    frame_d   = 1'b1;
                    ser_clk_d = 1'b0;
                    sdo_d     = bus.sar[WIDTH-1];
                end
`ifdef SAR_READOUT_TIMEOUT_EN
                else if (dwell_q == DWELL_MAX) begin
                    // Abandon this attempt; the period counter keeps the schedule
                    state_d = GAP;
                    cnvst_d = 1'b0;
                    tmo_d   = 1'b1;
                end
`endif
            end

            SHIFT: begin
                if (per_max) begin
                    overrun_d = 1'b1;
                end
                if (half_q == HALF_MAX) begin
                    state_d   = GAP;
                    frame_d   = 1'b0;
                    ser_clk_d = 1'b0;
                    sdo_d     = 1'b0;
                    count_d   = count_q + 16'd1;
                end else begin
                    half_d = half_q + 1'b1;
                    if (!half_q[0]) begin
                        ser_clk_d = 1'b1;
                    end else begin
                        // Falling ser_clk is the only point where sdo moves to the next bit
                        ser_clk_d = 1'b0;
                        shreg_d   = shreg_q << 1;
                        sdo_d     = shreg_q[WIDTH-2];
                    end
                end
            end

            GAP: begin
                if (per_max) begin
                    per_d = '0;
                    if (en) begin
                        state_d = CONV;
                        cnvst_d = 1'b1;
`ifdef SAR_READOUT_TIMEOUT_EN
                        dwell_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cnvst   = cnvst_q;
    assign bus.ser_clk = ser_clk_q;
    assign bus.sdo     = sdo_q;
    assign bus.frame   = frame_q;
    assign conv_count  = count_q;
    assign overrun     = overrun_q;
`ifdef SAR_READOUT_TIMEOUT_EN
    assign timeout_flag = tmo_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sar_readout_serializer.sv
// tb/tb_sar_readout_serializer.sv - randomized frame/schedule bench against an event-level model
module tb_sar_readout_serializer;

    logic       clk;
    logic       rst;
    logic [1:0] en_r;
    logic [1:0] eoc_r;
    logic [9:0] sar_r [2];
    wire  [1:0] cnvst_w, ser_clk_w, sdo_w, frame_w, ovr_w, tmo_w;
    wire  [15:0] cnt_w [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int         inst;
        int         edge_t;
        logic [9:0] code;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur;

    bit         mon_en = 1'b1;
    bit         sched_valid [2];
    int         rises [2];
    int         rise_t [2];
    int         exp_next [2];
    int         model_cnt [2];
    bit         model_ovr [2];
    int         flen [2];
    int         nbits [2];
    logic [9:0] bits [2];
    logic [9:0] cur_code [2];
    logic       cnvst_p [2];
    logic       frame_p [2];
    logic       ser_clk_p [2];
    logic       sdo_p [2];

    // Instance 0 uses the nominal period, instance 1 the tightest legal one
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sar_readout_serializer_if #(.WIDTH(10)) bus ();
        assign bus.eoc      = eoc_r[g];
        assign bus.sar      = sar_r[g];
        assign cnvst_w[g]   = bus.cnvst;
        assign ser_clk_w[g] = bus.ser_clk;
        assign sdo_w[g]     = bus.sdo;
        assign frame_w[g]   = bus.frame;
        sar_readout_serializer #(
            .WIDTH(10), .CONV_PERIOD(g == 0 ? 64 : 24), .TIMEOUT(40)
        ) dut (
            .clk(clk), .rst(rst), .en(en_r[g]), .bus(bus),
            .conv_count(cnt_w[g]), .overrun(ovr_w[g]), .timeout_flag(tmo_w[g])
        );
    end

    function automatic int cp_of(input int i);
        return (i == 0) ? 64 : 24;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event-level observer: frames, bit words, counts, overrun and cnvst schedule
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int i = 0; i < 2; i++) begin
                if (cnvst_w[i] && !cnvst_p[i]) begin
                    rises[i]++;
                    if (sched_valid[i]) check("cnvst_period", cyc, exp_next[i]);
                    sched_valid[i] = 1'b1;
                    rise_t[i] = cyc;
                end
                if (frame_w[i] && !frame_p[i]) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                        check("frame_unexpected", 1, 0);
                        cur_code[i] = 'x;
                    end else begin
                        cur = exp_q.pop_front();
                        cur_code[i] = cur.code;
                        check("frame_rise_edge", cyc, cur.edge_t);
                        check("first_sdo", int'(sdo_w[i]), int'(cur.code[9]));
                        check("cnvst_low_in_frame", int'(cnvst_w[i]), 0);
                        check("count_before_end", int'(cnt_w[i]), model_cnt[i]);
                    end
                    flen[i] = 0;
                    nbits[i] = 0;
                    bits[i] = '0;
                end
                if (frame_w[i]) begin
                    flen[i]++;
                    if (ser_clk_w[i] && !ser_clk_p[i]) begin
                        bits[i] = {bits[i][8:0], sdo_w[i]};
                        nbits[i]++;
                    end
                    if (ser_clk_w[i] && frame_p[i]) check("sdo_stable_high", int'(sdo_w[i]), int'(sdo_p[i]));
                end
                if (!frame_w[i] && frame_p[i]) begin
                    model_cnt[i]++;
                    check("frame_len", flen[i], 20);
                    check("bit_count", nbits[i], 10);
                    check("word", int'(bits[i]), int'(cur_code[i]));
                    check("conv_count", int'(cnt_w[i]), model_cnt[i]);
                    if (cyc >= rise_t[i] + cp_of(i)) model_ovr[i] = 1'b1;
                    check("overrun", int'(ovr_w[i]), int'(model_ovr[i]));
                    exp_next[i] = (rise_t[i] + cp_of(i) > cyc + 1) ? rise_t[i] + cp_of(i) : cyc + 1;
                end
                cnvst_p[i]   = cnvst_w[i];
                frame_p[i]   = frame_w[i];
                ser_clk_p[i] = ser_clk_w[i];
                sdo_p[i]     = sdo_w[i];
            end
        end
    end

    task automatic wait_cnvst(input int i);
        int n = 0;
        while (!cnvst_w[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cnvst_wait", int'(cnvst_w[i]), 1);
    endtask

    // Answer the next conversion with a one-cycle eoc pulse sampled d edges after cnvst rose
    task automatic serve(input int i, input int d, input logic [9:0] code);
        wait_cnvst(i);
        if (!cnvst_w[i]) return;
        repeat (d - 1) @(negedge clk);
        eoc_r[i] = 1'b1;
        sar_r[i] = code;
        exp_q.push_back('{inst: i, edge_t: cyc + 1, code: code});
        @(negedge clk);
        eoc_r[i] = 1'b0;
        sar_r[i] = 10'($urandom);
    endtask

    // eoc already high entering CONV, low 3 edges later, high again at edge 8
    task automatic serve_stuck(input int i, input logic [9:0] code);
        eoc_r[i] = 1'b1;
        sar_r[i] = ~code;
        wait_cnvst(i);
        if (!cnvst_w[i]) return;
        repeat (2) @(negedge clk);
        eoc_r[i] = 1'b0;
        repeat (5) @(negedge clk);
        eoc_r[i] = 1'b1;
        sar_r[i] = code;
        exp_q.push_back('{inst: i, edge_t: cyc + 1, code: code});
        @(negedge clk);
        eoc_r[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int n0;
        int cnt0;
        rst = 1'b1;
        en_r = '0;
        eoc_r = '0;
        sar_r[0] = '0;
        sar_r[1] = '0;
        for (int i = 0; i < 2; i++) begin
            sched_valid[i] = 0; rises[i] = 0; model_cnt[i] = 0; model_ovr[i] = 0;
            cnvst_p[i] = 0; frame_p[i] = 0; ser_clk_p[i] = 0; sdo_p[i] = 0;
        end
        #20;
        check("rst_cnvst", int'(cnvst_w[0]), 0);
        check("rst_frame", int'(frame_w[0]), 0);
        check("rst_count", int'(cnt_w[0]), 0);
        #10 rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("idle_cnvst", int'(cnvst_w[i]), 0);
            check("idle_ser_clk", int'(ser_clk_w[i]), 0);
            check("idle_sdo", int'(sdo_w[i]), 0);
            check("idle_frame", int'(frame_w[i]), 0);
            check("idle_count", int'(cnt_w[i]), 0);
            check("idle_overrun", int'(ovr_w[i]), 0);
            check("idle_timeout", int'(tmo_w[i]), 0);
        end

        // Nominal frames, then random codes and eoc latencies
        en_r[0] = 1'b1;
        serve(0, 12, 10'h2A5);
        for (int k = 0; k < 5; k++) serve(0, int'($urandom_range(2, 20)), 10'($urandom));
        serve_stuck(0, 10'($urandom));
        serve(0, int'($urandom_range(2, 20)), 10'($urandom));

        // Drop en mid-word: word completes, then the block parks
        serve(0, 8, 10'($urandom));
        repeat (5) @(negedge clk);
        en_r[0] = 1'b0;
        sched_valid[0] = 1'b0;
        n0 = rises[0];
        repeat (120) @(negedge clk);
        check("no_cnvst_when_disabled", rises[0], n0);
        check("parked_cnvst", int'(cnvst_w[0]), 0);
        check("overrun_nominal", int'(ovr_w[0]), 0);
        en_r[0] = 1'b1;
        @(negedge clk);
        check("restart", int'(cnvst_w[0]), 1);

        // eoc never arrives
        cnt0 = int'(cnt_w[0]);
        repeat (39) @(negedge clk);
        check("cnvst_before_timeout", int'(cnvst_w[0]), 1);
        @(negedge clk);
`ifdef SAR_READOUT_TIMEOUT_EN
        check("cnvst_at_timeout", int'(cnvst_w[0]), 0);
        check("timeout_flag", int'(tmo_w[0]), 1);
`else
        check("cnvst_waits", int'(cnvst_w[0]), 1);
        check("timeout_flag", int'(tmo_w[0]), 0);
`endif
        repeat (10) @(negedge clk);
        check("timeout_count", int'(cnt_w[0]), cnt0);
        check("timeout_no_frame", int'(frame_w[0]), 0);
        en_r[0] = 1'b0;

        // Tight period: late eoc overruns, word still completes, GAP is one cycle
        en_r[1] = 1'b1;
        serve(1, 10, 10'($urandom));
        serve(1, 3, 10'($urandom));
        for (int k = 0; k < 3; k++) serve(1, int'($urandom_range(1, 15)), 10'($urandom));
        repeat (30) @(negedge clk);
        check("overrun_sticky", int'(ovr_w[1]), 1);
        check("overrun_count", int'(cnt_w[1]), 5);

        // Reset in the middle of a word
        serve(1, 5, 10'($urandom));
        repeat (6) @(negedge clk);
        check("mid_frame_before_rst", int'(frame_w[1]), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_frame", int'(frame_w[1]), 0);
        check("rst_mid_ser_clk", int'(ser_clk_w[1]), 0);
        check("rst_mid_sdo", int'(sdo_w[1]), 0);
        check("rst_mid_cnvst", int'(cnvst_w[1]), 0);
        check("rst_mid_count", int'(cnt_w[1]), 0);
        check("rst_mid_overrun", int'(ovr_w[1]), 0);
        check("rst_mid_timeout", int'(tmo_w[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
